// File: rtl/prco_fetch.sv
// Instruction fetch sequencer: owns the PC, issues one-cycle fetch strobes to
// local memory, captures the returned word and hands it to decode.
module prco_fetch #(
    parameter logic [15:0] P_RESET_PC = 16'h0000,
    parameter int          P_PC_MAX   = 255,
    parameter int          P_TIMEOUT  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    output logic        q_ce_fetch,
    output logic [15:0] q_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic        q_valid,
    output logic [15:0] q_instr,
    output logic [15:0] q_pc,
    input  logic        i_ce_next,
    input  logic        i_jmp_en,
    input  logic [15:0] i_jmp_addr,
    input  logic        i_halt,
    output logic        q_halted,
    output logic        q_fault
);

    // state   | meaning
    // S_IDLE  | waiting for i_run
    // S_REQ   | fetch strobe asserted for this cycle
    // S_WAIT  | waiting for memory ack, timeout running
    // S_ISSUE | instruction valid, waiting for i_ce_next
    // S_HALT  | halted by decode, leave when i_run drops
    // S_FAULT | sticky fault, reset only
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [15:0] PC_MAX  = 16'(P_PC_MAX);
    localparam logic [7:0]  TIMEOUT = 8'(P_TIMEOUT);

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [7:0]  wait_cnt;

    assign pc_inc     = (pc == PC_MAX) ? 16'h0000 : pc + 16'h0001;
    assign q_ce_fetch = (state == S_REQ);
    assign q_mem_addr = pc;
    assign q_halted   = (state == S_HALT);
    assign q_fault    = (state == S_FAULT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            pc       <= P_RESET_PC;
            wait_cnt <= 8'd0;
            q_valid  <= 1'b0;
            q_instr  <= 16'h0000;
            q_pc     <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run)
                        state <= S_REQ;
                end
                S_REQ: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mem_ack) begin
                        q_instr <= i_mem_data;
                        q_pc    <= pc;
                        q_valid <= 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 >= TIMEOUT)
                            state <= S_FAULT;
                    end
                end
                S_ISSUE: begin
                    // halt outranks jump, jump outranks sequential increment
                    if (i_ce_next) begin
                        q_valid <= 1'b0;
                        if (i_halt) begin
                            state <= S_HALT;
                        end else if (i_jmp_en && (i_jmp_addr > PC_MAX)) begin
                            state <= S_FAULT;
                        end else begin
                            pc    <= i_jmp_en ? i_jmp_addr : pc_inc;
                            state <= i_run ? S_REQ : S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    if (!i_run)
                        state <= S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_fetch.sv
// Bench for prco_fetch: directed table, corner sequences, and random
// transaction stream checked against an address-sequence model.
module tb_prco_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_run;
    logic        q_ce_fetch;
    logic [15:0] q_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic        q_valid;
    logic [15:0] q_instr;
    logic [15:0] q_pc;
    logic        i_ce_next;
    logic        i_jmp_en;
    logic [15:0] i_jmp_addr;
    logic        i_halt;
    logic        q_halted;
    logic        q_fault;

    prco_fetch dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_run      (i_run),
        .q_ce_fetch (q_ce_fetch),
        .q_mem_addr (q_mem_addr),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data),
        .q_valid    (q_valid),
        .q_instr    (q_instr),
        .q_pc       (q_pc),
        .i_ce_next  (i_ce_next),
        .i_jmp_en   (i_jmp_en),
        .i_jmp_addr (i_jmp_addr),
        .i_halt     (i_halt),
        .q_halted   (q_halted),
        .q_fault    (q_fault)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // memory model: acks one cycle after a strobe, reads mem[addr]
    logic [15:0] mem [256];
    logic        ack_en;
    logic        ack_r = 1'b0;
    logic        force_ack;
    logic [15:0] rd_data = 16'h0000;

    always @(posedge i_clk) begin
        ack_r   <= ack_en && q_ce_fetch;
        rd_data <= mem[q_mem_addr[7:0]];
    end
    assign i_mem_ack  = ack_r | force_ack;
    assign i_mem_data = rd_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic prev_ce = 1'b0;
    always @(negedge i_clk) begin
        if (!i_reset && q_ce_fetch)
            chk("no_back_to_back_strobe", {31'd0, prev_ce}, 32'd0);
        prev_ce = q_ce_fetch;
    end

    task automatic wait_strobe();
        logic ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q_ce_fetch) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        chk("strobe_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid();
        logic ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        chk("valid_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic fetch_check(input logic [15:0] exp_addr);
        wait_strobe();
        chk("strobe_addr", {16'd0, q_mem_addr}, {16'd0, exp_addr});
        @(negedge i_clk);
        wait_valid();
        chk("issue_pc", {16'd0, q_pc}, {16'd0, exp_addr});
        chk("issue_instr", {16'd0, q_instr}, {16'd0, mem[exp_addr[7:0]]});
    endtask

    task automatic consume(input logic jen, input logic [15:0] ja, input logic halt);
        i_ce_next  = 1'b1;
        i_jmp_en   = jen;
        i_jmp_addr = ja;
        i_halt     = halt;
        @(negedge i_clk);
        i_ce_next = 1'b0;
        i_jmp_en  = 1'b0;
        i_halt    = 1'b0;
    endtask

    task automatic do_reset();
        i_reset   = 1'b1;
        i_run     = 1'b0;
        i_ce_next = 1'b0;
        i_jmp_en  = 1'b0;
        i_halt    = 1'b0;
        force_ack = 1'b0;
        ack_en    = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    typedef struct {
        logic        jen;
        logic [15:0] ja;
        logic        halt;
        logic [15:0] exp_addr;
        logic        exp_halt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t0;
        int n;
        int strobes;
        logic [15:0] exp_pc;
        logic [15:0] prev_instr;
        logic jen, drop;
        logic [15:0] ja;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0137) ^ 16'h5a00;
        mem[0] = 16'h4fff;
        mem[1] = 16'h16e0;

        tbl[0] = '{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tbl[1] = '{1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0};
        tbl[2] = '{1'b1, 16'h00aa, 1'b0, 16'h00aa, 1'b0};
        tbl[3] = '{1'b1, 16'h00ff, 1'b0, 16'h00ff, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{1'b1, 16'h0033, 1'b1, 16'h0000, 1'b1};

        i_jmp_addr = 16'h0000;
        do_reset();
        chk("reset_valid",  {31'd0, q_valid},    32'd0);
        chk("reset_strobe", {31'd0, q_ce_fetch}, 32'd0);
        chk("reset_addr",   {16'd0, q_mem_addr}, 32'd0);
        chk("reset_fault",  {31'd0, q_fault},    32'd0);
        chk("reset_halted", {31'd0, q_halted},   32'd0);
        chk("reset_instr",  {16'd0, q_instr},    32'd0);

        // first fetch and latency
        i_run = 1'b1;
        wait_strobe();
        t0 = cyc;
        chk("first_addr", {16'd0, q_mem_addr}, 32'd0);
        @(negedge i_clk);
        wait_valid();
        chk("first_latency", 32'(cyc - t0), 32'd2);
        chk("first_instr", {16'd0, q_instr}, 32'h4fff);
        chk("first_pc",    {16'd0, q_pc},    32'd0);

        for (int k = 0; k < 6; k++) begin
            consume(tbl[k].jen, tbl[k].ja, tbl[k].halt);
            if (tbl[k].exp_halt) begin
                chk("halted", {31'd0, q_halted}, 32'd1);
                strobes = 0;
                for (int i = 0; i < 8; i++) begin
                    if (q_ce_fetch) strobes++;
                    @(negedge i_clk);
                end
                chk("halt_no_strobe", 32'(strobes), 32'd0);
                chk("halt_valid", {31'd0, q_valid}, 32'd0);
            end else begin
                fetch_check(tbl[k].exp_addr);
            end
        end

        // resume from halt at the unchanged pc
        i_run = 1'b0;
        @(negedge i_clk);
        chk("halt_cleared", {31'd0, q_halted}, 32'd0);
        i_run = 1'b1;
        fetch_check(16'h0000);

        // out-of-range jump faults
        consume(1'b1, 16'h0100, 1'b0);
        chk("jmp_fault", {31'd0, q_fault}, 32'd1);
        chk("jmp_fault_valid", {31'd0, q_valid}, 32'd0);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            if (q_ce_fetch || q_valid) strobes++;
            @(negedge i_clk);
        end
        chk("fault_quiet", 32'(strobes), 32'd0);
        chk("fault_sticky", {31'd0, q_fault}, 32'd1);

        // memory timeout at pc=1, then async reset mid-cycle
        do_reset();
        i_run = 1'b1;
        fetch_check(16'h0000);
        consume(1'b0, 16'h0000, 1'b0);
        ack_en = 1'b0;
        wait_strobe();
        chk("timeout_addr", {16'd0, q_mem_addr}, 32'd1);
        n = 0;
        while (!q_fault && n < 12) begin
            @(negedge i_clk);
            n++;
        end
        chk("timeout_wait_cycles", 32'(n - 1), 32'd4);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("async_fault",  {31'd0, q_fault},    32'd0);
        chk("async_addr",   {16'd0, q_mem_addr}, 32'd0);
        chk("async_instr",  {16'd0, q_instr},    32'd0);
        chk("async_valid",  {31'd0, q_valid},    32'd0);
        chk("async_strobe", {31'd0, q_ce_fetch}, 32'd0);
        chk("async_halted", {31'd0, q_halted},   32'd0);

        // reset during S_WAIT with a late ack right after release
        do_reset();
        ack_en = 1'b0;
        i_run  = 1'b1;
        wait_strobe();
        @(negedge i_clk);
        i_run   = 1'b0;
        i_reset = 1'b1;
        #2 i_reset = 1'b0;
        force_ack = 1'b1;
        @(negedge i_clk);
        force_ack = 1'b0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            if (q_valid || q_ce_fetch) strobes++;
            @(negedge i_clk);
        end
        chk("late_ack_ignored", 32'(strobes), 32'd0);
        ack_en = 1'b1;
        i_run  = 1'b1;
        fetch_check(16'h0000);

        // random stream against the address-sequence model
        do_reset();
        i_run  = 1'b1;
        exp_pc = 16'h0000;
        for (int t = 0; t < 200; t++) begin
            fetch_check(exp_pc);
            prev_instr = mem[exp_pc[7:0]];
            n = $urandom_range(0, 3);
            for (int d = 0; d < n; d++) begin
                i_jmp_en   = 1'($urandom);
                i_halt     = 1'($urandom);
                i_jmp_addr = 16'($urandom);
                force_ack  = 1'($urandom);
                @(negedge i_clk);
            end
            force_ack = 1'b0;
            chk("hold_instr", {16'd0, q_instr}, {16'd0, prev_instr});
            chk("hold_valid", {31'd0, q_valid}, 32'd1);
            jen  = ($urandom_range(0, 3) == 0);
            ja   = 16'($urandom_range(0, 255));
            drop = ($urandom_range(0, 7) == 0);
            if (drop) i_run = 1'b0;
            consume(jen, ja, 1'b0);
            exp_pc = jen ? ja : ((exp_pc == 16'd255) ? 16'd0 : exp_pc + 16'd1);
            if (drop) begin
                strobes = 0;
                for (int d = 0; d < 2; d++) begin
                    if (q_ce_fetch) strobes++;
                    @(negedge i_clk);
                end
                chk("run_drop_idle", 32'(strobes), 32'd0);
                i_run = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
